// File: rtl/mm_stage_ctrl.sv
// Memory-stage handshake controller: issues data-SRAM requests for MM1, tracks
// outstanding and flush-cancelled responses, and gates the MM1->MM2 advance.
module mm_stage_ctrl #(
    parameter int MAX_OUTST = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mm1_valid,
    input  logic       mm1_mem_req,
    input  logic       mm1_excp,
    input  logic       wb_allowin,
    input  logic       excp_flush,
    output logic       data_sram_req,
    input  logic       data_sram_addr_ok,
    input  logic       data_sram_data_ok,
    output logic       mm1_allowin,
    output logic       mm1_mm2_wen,
    output logic       mm1_mm2_flush,
    output logic       mm2_valid,
    output logic       mm2_data_valid,
    output logic [1:0] outst_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       req_hold;
    logic       req_hold_nxt;
    logic [1:0] cancel_cnt;
    logic [1:0] cancel_nxt;
    logic [1:0] outst_nxt;
    logic [2:0] flush_cancel;
    logic       mm1_sent;
    logic       mm2_mem_pend;

    logic       mm1_need;
    logic       new_req;
    logic       addr_acc;
    logic       mm1_acc;
    logic       data_ret;
    logic       cancel_ret;
    logic       mm1_ready;
    logic       mm2_ready;
    logic       mm2_allowin;
    logic       mm2_leave;

    assign mm1_need = mm1_valid & mm1_mem_req & ~mm1_excp;

    // A fresh request is never started while draining, so any acceptance seen in
    // DRAIN belongs to the held, already-cancelled request.
    assign new_req = mm1_need & ~excp_flush & (outst_cnt < 2'(MAX_OUTST))
                   & (cancel_cnt == 2'd0) & ~mm1_sent & (state != DRAIN);

    // Reset gates the combinational outputs so they read 0 for the whole reset window.
    assign data_sram_req = rst_n & (req_hold | new_req);
    assign mm1_mm2_flush = rst_n & excp_flush;

    assign addr_acc   = data_sram_req & data_sram_addr_ok;
    assign mm1_acc    = addr_acc & (state != DRAIN);
    assign data_ret   = data_sram_data_ok & (outst_cnt != 2'd0);
    assign cancel_ret = data_ret & (cancel_cnt != 2'd0);

    assign mm1_ready      = ~mm1_valid | ~mm1_mem_req | mm1_excp | mm1_sent | mm1_acc;
    assign mm2_data_valid = data_ret & (cancel_cnt == 2'd0) & mm2_valid & mm2_mem_pend;
    assign mm2_ready      = ~mm2_mem_pend | mm2_data_valid;
    assign mm2_leave      = mm2_ready & wb_allowin;
    assign mm2_allowin    = ~mm2_valid | mm2_leave;
    assign mm1_mm2_wen    = mm1_ready & mm2_allowin & ~excp_flush;
    assign mm1_allowin    = ~mm1_valid | mm1_mm2_wen;

    assign outst_nxt    = outst_cnt + {1'b0, addr_acc} - {1'b0, data_ret};
    assign flush_cancel = {1'b0, outst_cnt} + {2'b00, addr_acc} - {2'b00, data_ret};

    // NOTE: combinational blocks use blocking '=' with every output defaulted first,
    // which keeps them free of inferred latches; sequential blocks use '<=' only.
    always_comb begin
        state_nxt    = state;
        cancel_nxt   = cancel_cnt;
        req_hold_nxt = data_sram_req & ~data_sram_addr_ok;
        if (excp_flush) begin
            cancel_nxt = flush_cancel[1:0];
            state_nxt  = ((cancel_nxt != 2'd0) || req_hold_nxt) ? DRAIN : IDLE;
        end else begin
            case (state)
                IDLE, REQ: begin
                    state_nxt = req_hold_nxt ? REQ : IDLE;
                end
                DRAIN: begin
                    cancel_nxt = cancel_cnt + {1'b0, addr_acc} - {1'b0, cancel_ret};
                    state_nxt  = ((cancel_nxt == 2'd0) && !req_hold_nxt) ? IDLE : DRAIN;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_hold   <= 1'b0;
            cancel_cnt <= 2'd0;
            outst_cnt  <= 2'd0;
        end else begin
            req_hold   <= req_hold_nxt;
            cancel_cnt <= cancel_nxt;
            outst_cnt  <= outst_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm1_sent <= 1'b0;
        end else if (excp_flush || mm1_mm2_wen) begin
            mm1_sent <= 1'b0;
        end else if (mm1_acc) begin
            mm1_sent <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm2_valid    <= 1'b0;
            mm2_mem_pend <= 1'b0;
        end else if (excp_flush) begin
            mm2_valid    <= 1'b0;
            mm2_mem_pend <= 1'b0;
        end else if (mm1_mm2_wen) begin
            mm2_valid    <= mm1_valid;
            mm2_mem_pend <= mm1_need;
        end else begin
            if (mm2_leave) begin
                mm2_valid <= 1'b0;
            end
            // The response is a one-cycle pulse; once it has been delivered to a
            // stalled MM2 it must not be matched against the next response.
            if (mm2_data_valid) begin
                mm2_mem_pend <= 1'b0;
            end
        end
    end

endmodule
